mult_sequencer: RTL
===================

Name: mult_sequencer

Overview:
- Control FSM for the 8-bit signed add-shift multiplier datapath (A/B registers, X sign bit, 9-bit adder).
- Sequences one multiply per Run request: clear A/X, then WIDTH add/shift pairs, with a subtract replacing the add on the final step (two's-complement multiplier B).
- Also gates register load/clear requests so they only reach the datapath while it is idle.
- Sits between the switch/button inputs and the datapath register/adder enables.

Parameters:
- WIDTH, 8, operand width; number of add/shift iterations.
- CW, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  level request to start a multiply.
- ClearA_LoadB  in  1  level request to clear A/X and load B from switches.
- M  in  1  current LSB of register B, driven by the datapath.
- clr_ld  out  1  datapath clear-A/X plus load-B enable.
- clear_a  out  1  datapath clear-A/X only; B is kept.
- add  out  1  load A/X with A + (S sign-extended).
- sub  out  1  load A/X with A − (S sign-extended).
- shift  out  1  arithmetic right shift of X:A:B by one bit.
- busy  out  1  multiply in progress.
- done  out  1  multiply complete; result valid in A:B.
- count  out  CW  completed shift iterations.

Behaviour:
- Reset = 1 at a rising edge: state goes to IDLE and count to 0. All outputs are 0 in the following cycle.
- Reset has priority over every other input in every state. Reset mid-multiply abandons the operation; datapath contents are then don't-care.
- States: IDLE, CLEAR, ADD, SHIFT, DONE.
- IDLE:
  - clr_ld = ClearA_LoadB. This is combinational and asserts for as many cycles as the input is held.
  - If ClearA_LoadB = 1: stay in IDLE. Run is ignored that cycle; ClearA_LoadB wins any tie.
  - Else if Run = 1: go to CLEAR.
- CLEAR (1 cycle):
  - Outputs: clear_a = 1, busy = 1.
  - count <= 0, then go to ADD.
- ADD (1 cycle):
  - busy = 1.
  - If count < WIDTH−1: add = M.
  - If count = WIDTH−1: sub = M.
  - add and sub are Mealy outputs on M and are never both 1.
  - Go to SHIFT.
- SHIFT (1 cycle):
  - Outputs: shift = 1, busy = 1.
  - count <= count + 1.
  - If count + 1 = WIDTH: go to DONE. Else go to ADD.
- DONE:
  - done = 1; busy = 0; count holds at WIDTH.
  - Stay while Run = 1, so a held Run never starts a second multiply.
  - Go to IDLE on Run = 0. count stays at WIDTH until the next CLEAR.
- Latency: Run is sampled high in IDLE at edge 0.
  - CLEAR is the cycle after edge 0.
  - busy lasts 1 + 2·WIDTH cycles (17 for WIDTH = 8).
  - done first asserts in the cycle after the edge that exits the final SHIFT (cycle 18).
- ClearA_LoadB while busy or in DONE is ignored: clr_ld = 0 in CLEAR/ADD/SHIFT/DONE.
- Run changes while busy are ignored.
- Outputs are mutually exclusive per cycle: at most one of clr_ld, clear_a, add, sub, shift is 1.
- Undefined state encodings recover to IDLE on the next edge.

Test Plan:
- Reset/idle:
  - Stimulus: Reset = 1 for 2 cycles, then Reset = 0 with all inputs 0.
  - Response: all outputs 0, count = 0, state stays IDLE.
- Load gating:
  - Stimulus: ClearA_LoadB = 1 for 3 cycles in IDLE.
  - Response: clr_ld = 1 for exactly those 3 cycles; busy = 0.
  - Stimulus: Run = 1 and ClearA_LoadB = 1 together.
  - Response: stays IDLE; starts only after ClearA_LoadB drops.
- Multiply, B = 0x02:
  - Stimulus: bench models B shifting LSB-first, so M sequence is 0,1,0,0,0,0,0,0.
  - Response: clear_a in cycle 1; add = 1 only in the ADD with count = 1; sub never asserts; shift asserts 8 times.
  - Response: done = 1 at cycle 18; count = 8.
- Multiply, B = 0xFE:
  - Stimulus: M sequence 0,1,1,1,1,1,1,1.
  - Response: add = 1 for count = 1..6; sub = 1 only at count = 7; add never asserts at count = 7.
- Run hold/release:
  - Stimulus: hold Run = 1 for 10 cycles after done.
  - Response: done stays 1 and no new CLEAR occurs.
  - Stimulus: release Run, then reassert it.
  - Response: IDLE on the next edge; CLEAR in the cycle after Run is reasserted.
- Abort:
  - Stimulus: Reset = 1 while count = 4 in SHIFT.
  - Response: next cycle IDLE, all outputs 0, count = 0.
  - Stimulus: ClearA_LoadB = 1 mid-multiply.
  - Response: clr_ld stays 0 and the sequence is unchanged.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control FSM for the 8-bit signed add-shift multiplier datapath.
// Sequences clear, WIDTH add/shift pairs (subtract on the last) and gates idle-time loads.
module mult_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          clr_ld,
  output logic          clear_a,
  output logic          add,
  output logic          sub,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ALL_STEPS = CW'(WIDTH);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clr_ld  = 1'b0;
    clear_a = 1'b0;
    add     = 1'b0;
    sub     = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A pending load always wins over a start request.
        clr_ld = ClearA_LoadB;
        if (!ClearA_LoadB && Run) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clear_a = 1'b1;
        busy    = 1'b1;
        count_d = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        busy = 1'b1;
        // The multiplier MSB carries negative weight, so the last partial product is subtracted.
        if (count_q == LAST_STEP) sub = M;
        else                      add = M;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift   = 1'b1;
        busy    = 1'b1;
        count_d = count_q + 1'b1;
        state_d = (count_d == ALL_STEPS) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        done = 1'b1;
        if (!Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign dbg_state = state_q;

endmodule
